// File: rtl/pipeline_pkg.sv
// Shared definitions for the forwarding/hazard unit: forward-select encodings and the
// shadow-pipeline entry that tracks one in-flight instruction.
package pipeline_pkg;

  localparam int unsigned REG_NUM_BITWIDTH = 5;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef struct packed {
    logic [REG_NUM_BITWIDTH-1:0] rd;
    logic                        reg_write;
    logic                        mem_read;
  } shadow_entry_t;

  localparam int unsigned SHADOW_ENTRY_W = $bits(shadow_entry_t);

  localparam shadow_entry_t BUBBLE = '0;

  // A source hits an entry when it is really read, is not x0, and the entry writes it.
  function automatic logic src_hits(logic [REG_NUM_BITWIDTH-1:0] rs, logic uses,
                                    shadow_entry_t entry);
    return uses && (rs != '0) && entry.reg_write && (entry.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Compares one ID source register against the EX and MEM shadow entries and returns the
// forward select it would need once it reaches execute.
module fwd_select
  import pipeline_pkg::*;
(
  input  logic [REG_NUM_BITWIDTH-1:0] rs,
  input  logic                        uses,
  input  shadow_entry_t               ex_entry,
  input  shadow_entry_t               mem_entry,
  output logic [1:0]                  sel,
  output logic                        ex_hit
);

  logic mem_hit;

  always_comb begin
    ex_hit  = src_hits(rs, uses, ex_entry);
    mem_hit = src_hits(rs, uses, mem_entry);
    sel     = FWD_REG;
    // The EX entry is the youngest writer, so it shadows an older MEM writer of the same rd.
    if (ex_hit) begin
      sel = FWD_EX_MEM;
    end else if (mem_hit) begin
      sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control: shadows the EX/MEM/WB destinations, registers the
// execute-stage forward selects, raises stall for load-use pairs and counts stall cycles.
module fwd_hazard_unit #(
  parameter int unsigned REG_NUM_BITWIDTH = 5,
  parameter int unsigned CNT_BITWIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
  input  logic                        id_uses_rs1,
  input  logic                        id_uses_rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rd,
  input  logic                        id_regWrite,
  input  logic                        id_memRead,
  input  logic                        flush,
  output logic [1:0]                  forwardA,
  output logic [1:0]                  forwardB,
  output logic                        stall,
  output logic [CNT_BITWIDTH-1:0]     stall_count
);

  pipeline_pkg::shadow_entry_t ex_q, ex_d;
  pipeline_pkg::shadow_entry_t mem_q, mem_d;
  pipeline_pkg::shadow_entry_t wb_q, wb_d;
  pipeline_pkg::shadow_entry_t id_entry;

  logic [1:0]              fwd_a_q, fwd_a_d;
  logic [1:0]              fwd_b_q, fwd_b_d;
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;

  logic [1:0] sel_a, sel_b;
  logic       ex_hit_a, ex_hit_b;
  logic       take_id;

  fwd_select u_fwd_select_rs1 (
    .rs        (id_rs1),
    .uses      (id_uses_rs1),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
    .sel       (sel_a),
    .ex_hit    (ex_hit_a)
  );

  fwd_select u_fwd_select_rs2 (
    .rs        (id_rs2),
    .uses      (id_uses_rs2),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
    .sel       (sel_b),
    .ex_hit    (ex_hit_b)
  );

  always_comb begin
    id_entry           = pipeline_pkg::BUBBLE;
    id_entry.rd        = id_rd;
    id_entry.reg_write = id_regWrite;
    id_entry.mem_read  = id_memRead;

    // A load in EX cannot supply its data until MEM, so its consumer waits one cycle.
    stall   = id_valid && !flush && ex_q.mem_read && (ex_hit_a || ex_hit_b);
    take_id = id_valid && !stall && !flush;

    ex_d  = take_id ? id_entry : pipeline_pkg::BUBBLE;
    mem_d = flush ? pipeline_pkg::BUBBLE : ex_q;
    wb_d  = mem_q;

    fwd_a_d = take_id ? sel_a : pipeline_pkg::FWD_REG;
    fwd_b_d = take_id ? sel_b : pipeline_pkg::FWD_REG;

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= pipeline_pkg::BUBBLE;
      mem_q   <= pipeline_pkg::BUBBLE;
      wb_q    <= pipeline_pkg::BUBBLE;
      fwd_a_q <= pipeline_pkg::FWD_REG;
      fwd_b_q <= pipeline_pkg::FWD_REG;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign forwardA    = fwd_a_q;
  assign forwardB    = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against an instruction-history model.
module tb_fwd_hazard_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_regWrite, id_memRead, flush;
  logic [1:0]    forwardA, forwardB;
  logic          stall;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_NUM_BITWIDTH (5),
    .CNT_BITWIDTH     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_regWrite (id_regWrite),
    .id_memRead  (id_memRead),
    .flush       (flush),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .stall       (stall),
    .stall_count (stall_count)
  );

  // Issued-instruction history by age: 0 is in EX, 1 in MEM, 2 in WB.
  typedef struct {
    logic [4:0] rd;
    bit         wr;
    bit         ld;
  } slot_t;

  slot_t hist[3];
  int    m_fa, m_fb, m_cnt;
  int    n_vec, n_err;
  bit    last_stall;

  // Select needed by a source: nearest older producer wins, age 0 via EX/MEM, age 1 via MEM/WB.
  function automatic int producer(logic [4:0] rs, bit uses);
    if (!uses || rs == 5'd0) return 0;
    for (int age = 0; age < 2; age++) begin
      if (hist[age].wr && hist[age].rd == rs) return (age == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int rs1, input bit u1, input int rs2,
                      input bit u2, input int rd, input bit wr, input bit ld, input bit fl);
    bit    m_stall, take;
    int    na, nb;
    slot_t bub;
    rst = r; id_valid = v; flush = fl;
    id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_regWrite = wr; id_memRead = ld;
    #1;
    m_stall = v && !fl && hist[0].ld && (producer(5'(rs1), u1) == 2 || producer(5'(rs2), u2) == 2);
    check("stall", int'(stall), int'(m_stall));
    check("forwardA", int'(forwardA), m_fa);
    check("forwardB", int'(forwardB), m_fb);
    check("stall_count", int'(stall_count), m_cnt);
    last_stall = stall;
    @(posedge clk);
    bub = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
    if (r) begin
      for (int i = 0; i < 3; i++) hist[i] = bub;
      m_fa = 0; m_fb = 0; m_cnt = 0;
    end else begin
      take = v && !m_stall && !fl;
      na = take ? producer(5'(rs1), u1) : 0;
      nb = take ? producer(5'(rs2), u2) : 0;
      hist[2] = hist[1];
      hist[1] = fl ? bub : hist[0];
      hist[0] = take ? '{rd: 5'(rd), wr: wr, ld: ld} : bub;
      m_fa = na; m_fb = nb;
      if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1; id_valid = 0; flush = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_regWrite = 0; id_memRead = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) hist[i] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
    m_fa = 0; m_fb = 0; m_cnt = 0;
    #1;
    check("reset_stall", int'(stall), 0);
    check("reset_fa", int'(forwardA), 0);
    check("reset_cnt", int'(stall_count), 0);

    // add x5 in EX, consumer reads rs1
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 1, 5, 1, 6, 1, 8, 1, 0, 0);
    check("exmem_fa", int'(forwardA), 2);
    check("exmem_fb", int'(forwardB), 0);
    check("exmem_nostall", int'(last_stall), 0);

    // add x5 in MEM, consumer reads rs2
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 5, 1, 9, 1, 0, 0);
    check("memwb_fb", int'(forwardB), 1);

    // x5 written twice back to back: youngest wins
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 1, 5, 1, 0, 0, 9, 1, 0, 0);
    check("youngest_fa", int'(forwardA), 2);

    // lw x7 then consumer: one stall cycle, bubble, then MEM/WB forward
    do_reset();
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0);
    check("lu_stall", int'(last_stall), 1);
    check("lu_bubble_fa", int'(forwardA), 0);
    check("lu_cnt", int'(stall_count), 1);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0);
    check("lu_stall_once", int'(last_stall), 0);
    check("lu_fa", int'(forwardA), 1);

    // x0 is never forwarded
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    check("x0_stall", int'(last_stall), 0);
    check("x0_fa", int'(forwardA), 0);
    check("x0_fb", int'(forwardB), 0);

    // flush beats load-use stall and kills the load in EX
    do_reset();
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 1);
    check("flush_stall", int'(last_stall), 0);
    check("flush_fa", int'(forwardA), 0);
    check("flush_cnt", int'(stall_count), 0);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0);
    check("flush_killed_fa", int'(forwardA), 0);

    // reset during a stall
    do_reset();
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(1, 1, 7, 1, 0, 0, 9, 1, 0, 0);
    check("rststall_seen", int'(last_stall), 1);
    step(0, 1, 7, 1, 0, 0, 9, 1, 0, 0);
    check("rststall_clear", int'(last_stall), 0);
    check("rststall_cnt", int'(stall_count), 0);

    // counter saturation
    do_reset();
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
      step(0, 1, 0, 0, 7, 1, 9, 0, 0, 0);
    end
    check("sat_cnt", int'(stall_count), (1 << CW) - 1);

    // randomized traffic on a small register set to provoke hazards
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and hazard control unit for the 5-stage RISC-V pipeline; produces the forwardA/forwardB selects and fwd data-path alignment that the execute stage consumes. Tracks the destination register, write-enable and load flag of every instruction in EX, MEM and WB in an internal shadow pipeline, compares them against the source registers of the instruction in ID, and registers the resulting selects into the ID/EX boundary. Also detects load-use hazards (stall plus bubble), applies branch flushes to its shadow pipeline, and counts stall cycles.

## Interface
- REG_NUM_BITWIDTH, 5, register index width
- CNT_BITWIDTH, 16, stall counter width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_NUM_BITWIDTH  source registers of ID instruction
- id_uses_rs1, id_uses_rs2  in  1  instruction reads that source
- id_rd  in  REG_NUM_BITWIDTH  destination of ID instruction
- id_regWrite, id_memRead  in  1  ID instruction writes rd / is a load
- flush  in  1  branch/jump resolved taken in EX; kill ID and EX instructions
- forwardA, forwardB  out  2  registered selects for the instruction now in EX: 00 register file, 10 EX/MEM, 01 MEM/WB; 11 never driven
- stall  out  1  combinational; hold PC and IF/ID, insert bubble into ID/EX
- stall_count  out  CNT_BITWIDTH  saturating count of stall cycles

## Operation
- Shadow pipeline: three entries {rd, regWrite, memRead} for EX, MEM, WB. Each cycle: WB<=MEM, MEM<=EX, EX<=ID-entry or bubble. Bubble = all fields zero.
- ID-entry is taken when id_valid & !stall & !flush; otherwise bubble enters EX.
- Match rule for a source s: id_uses_s & (id_rs_s != 0) & entry.regWrite & (entry.rd == id_rs_s).
- Select computed in ID, registered on clk: match against EX entry -> 10 (becomes EX/MEM next cycle); else match against MEM entry -> 01 (becomes MEM/WB); else 00. EX match has priority.
- x0 never forwarded regardless of regWrite.
- Load-use: stall = id_valid & !flush & EX.memRead & (match on rs1 or rs2 against EX entry). While stall, registered selects load 00 (bubble).
- After a one-cycle stall, the load is in MEM; the same ID instruction recompares and gets 01.
- flush: EX entry and next-EX entry become bubbles; stall suppressed; forwardA/B register 00. MEM and WB entries unaffected.
- WB-to-ID hazard is out of scope: register file is write-first.
- stall_count increments every cycle stall=1; holds at all-ones.

## Timing
- Reset: all shadow entries bubble, forwardA=forwardB=00, stall_count=0; stall=0 since EX is a bubble.
- forwardA/B latency: one cycle (valid for exactly the cycle the instruction sits in EX).
- stall is same-cycle combinational; stall length for a load-use pair is exactly one cycle.
- flush and stall same cycle: flush wins, stall=0, count not incremented.
- Reset mid-stall: next cycle stall=0, all entries cleared.
- Back-to-back writers of same rd: youngest (EX entry) wins.

## Structure
- Package pipeline_pkg: FWD_REG=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, shadow-entry struct/width, REG_NUM_BITWIDTH.
- One sub-module: fwd_select — combinational compare of one source against EX and MEM entries returning the 2-bit select; instantiated twice (rs1, rs2).
- Shadow pipeline and counter in top level.

## Test plan
- add x5 in EX, ID reads rs1=x5 -> next cycle forwardA=10, forwardB=00, stall=0.
- add x5 in MEM, ID reads rs2=x5 -> next cycle forwardB=01.
- x5 written in both EX and MEM entries, ID reads rs1=x5 -> forwardA=10.
- lw x7 in EX, ID reads rs1=x7 -> stall=1 one cycle, forwardA=00 during bubble, then forwardA=01; stall_count=1.
- ID writes/reads x0, prior writer to x0 -> forwardA=forwardB=00, no stall.
- lw x7 in EX, ID reads x7, flush=1 same cycle -> stall=0, forward 00, EX entry bubble next cycle; counter at 2^16-1 stays saturated under further stalls.
